// File: rtl/demux4_sched.sv
// One-entry holding register that steers each upstream word to one of four lanes,
// round-robin or fixed. Define DEMUX4_SCHED_STATS_EN to implement the skip_cnt counter.
module demux4_sched #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              mode,
   input  logic [1:0]        fixed_sel,
   output logic [1:0]        sel,
   output logic [DATA_W-1:0] out_data0,
   output logic [DATA_W-1:0] out_data1,
   output logic [DATA_W-1:0] out_data2,
   output logic [DATA_W-1:0] out_data3,
   output logic [3:0]        out_valid,
   input  logic [3:0]        out_ready,
   output logic [7:0]        skip_cnt
);

   // Handshakes: a word moves on a rising edge where valid and ready are both 1.
   // valid never waits on ready, and in_ready/out_valid depend only on registered state.

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t            state, state_nx;
   logic [DATA_W-1:0] held, held_nx;
   logic [1:0]        sel_q, sel_nx;
   logic [1:0]        rr_ptr, rr_nx;
   logic [7:0]        wait_cnt, wait_nx;
   logic              fixed_q, fixed_nx;
   logic              lane_rdy;

   assign lane_rdy = out_ready[sel_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         held     <= '0;
         sel_q    <= 2'd0;
         rr_ptr   <= 2'd0;
         wait_cnt <= 8'd0;
         fixed_q  <= 1'b0;
      end else begin
         state    <= state_nx;
         held     <= held_nx;
         sel_q    <= sel_nx;
         rr_ptr   <= rr_nx;
         wait_cnt <= wait_nx;
         fixed_q  <= fixed_nx;
      end
   end

   always_comb begin
      state_nx = state;
      held_nx  = held;
      sel_nx   = sel_q;
      rr_nx    = rr_ptr;
      wait_nx  = wait_cnt;
      fixed_nx = fixed_q;
      case (state)
         IDLE: begin
            if (in_valid) begin
               held_nx  = in_data;
               fixed_nx = mode;
               sel_nx   = mode ? fixed_sel : rr_ptr;
               wait_nx  = 8'd0;
               state_nx = HOLD;
            end
         end
         HOLD: begin
            // A ready lane always wins over a timeout firing on the same edge.
            if (lane_rdy) begin
               state_nx = IDLE;
               if (!fixed_q) rr_nx = sel_q + 2'd1;
            end else if (!fixed_q) begin
               if (wait_cnt == WAIT_LAST) begin
                  sel_nx  = sel_q + 2'd1;
                  wait_nx = 8'd0;
               end else begin
                  wait_nx = wait_cnt + 8'd1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

`ifdef DEMUX4_SCHED_STATS_EN
   logic       retarget;
   logic [7:0] skip_q;

   assign retarget = (state == HOLD) && !lane_rdy && !fixed_q && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (rst)                              skip_q <= 8'd0;
      else if (retarget && skip_q != 8'hFF) skip_q <= skip_q + 8'd1;
   end

   assign skip_cnt = skip_q;
`else
   assign skip_cnt = 8'd0;
`endif

   assign in_ready  = (state == IDLE);
   assign sel       = sel_q;
   assign out_valid = (state == HOLD) ? (4'b0001 << sel_q) : 4'b0000;
   assign out_data0 = out_valid[0] ? held : '0;
   assign out_data1 = out_valid[1] ? held : '0;
   assign out_data2 = out_valid[2] ? held : '0;
   assign out_data3 = out_valid[3] ? held : '0;

endmodule
